// File: rtl/pulse_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pulse_scheduler_if                                            |
// | Purpose  : Request/config bundle and shared pulse outputs between the    |
// |            requesters (master side) and pulse_scheduler (slave side).    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface pulse_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 4,
  parameter int CNT_W = 4
);
  // Requester side: level requests plus packed per-requester configuration.
  logic [NREQ-1:0]       req;
  logic [NREQ*DIV_W-1:0] div_cfg;
  logic [NREQ*CNT_W-1:0] cnt_cfg;

  // Scheduler side: ownership, shared waveform and completion strobes.
  logic [NREQ-1:0]       grant;
  logic                  pulse_out;
  logic                  busy;
  logic [NREQ-1:0]       done;

  modport master (
    output req, div_cfg, cnt_cfg,
    input  grant, pulse_out, busy, done
  );

  modport slave (
    input  req, div_cfg, cnt_cfg,
    output grant, pulse_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/pulse_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pulse_scheduler                                               |
// | Purpose  : Shares one divide-by-D pulse generator among NREQ requesters. |
// |            A granted requester gets exactly cnt full periods of 2*D      |
// |            cycles on pulse_out, then a one-cycle done strobe.            |
// | Option   : PULSE_SCHED_FIXPRIO_EN - fixed priority (lowest index wins)   |
// |            instead of the default round-robin arbitration.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pulse_scheduler #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 4,
  parameter int CNT_W = 4
) (
  input  wire logic        clock,
  input  wire logic        reset_n,
  pulse_scheduler_if.slave bus
);

  // Requester index width; at least one bit even for tiny NREQ.
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // State and datapath registers with their next-state values
  // ---------------------------------------------------------------------
  state_t            r_state,   w_state_nxt;
  logic [NREQ-1:0]   r_grant,   w_grant_nxt;
  logic [NREQ-1:0]   r_done,    w_done_nxt;
  logic              r_pulse,   w_pulse_nxt;
  logic [DIV_W-1:0]  r_div_cnt, w_div_cnt_nxt;
  logic [CNT_W:0]    r_tog_cnt, w_tog_cnt_nxt;
  logic [DIV_W-1:0]  r_div,     w_div_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [IDX_W-1:0]  r_owner,   w_owner_nxt;
`ifdef PULSE_SCHED_FIXPRIO_EN
  // Fixed priority needs no rotating pointer.
`else
  logic [IDX_W-1:0]  r_rr,      w_rr_nxt;
`endif

  // ---------------------------------------------------------------------
  // Arbitration and run-time helper signals
  // ---------------------------------------------------------------------
  logic              w_found;
  logic [IDX_W-1:0]  w_sel;
  logic [NREQ-1:0]   w_sel_oh;
  logic [DIV_W-1:0]  w_sel_div;
  logic [CNT_W-1:0]  w_sel_cnt;
  logic [DIV_W-1:0]  w_div_last;
  logic [CNT_W:0]    w_tog_inc;
  logic [CNT_W:0]    w_tog_target;
  logic              w_owner_req;

`ifdef PULSE_SCHED_FIXPRIO_EN
`else
  // (base + off) mod NREQ, valid for non-power-of-two NREQ as well.
  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned base,
                                                input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end
    return IDX_W'(s);
  endfunction
`endif

  // Pick the winning requester among the currently raised requests.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef PULSE_SCHED_FIXPRIO_EN
      if (!w_found && bus.req[k]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(k);
      end
`else
      if (!w_found && bus.req[wrap_idx(r_rr, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_idx(r_rr, k);
      end
`endif
    end
  end

  // Winner one-hot and its configuration fields, sampled only on grant.
  assign w_sel_oh  = NREQ'(1) << w_sel;
  assign w_sel_div = bus.div_cfg[int'(w_sel)*DIV_W +: DIV_W];
  assign w_sel_cnt = bus.cnt_cfg[int'(w_sel)*CNT_W +: CNT_W];

  // A latched divisor of zero behaves as one, so the last count is 0.
  assign w_div_last   = (r_div == '0) ? '0 : (r_div - DIV_W'(1));
  assign w_tog_inc    = r_tog_cnt + (CNT_W+1)'(1);
  // Two toggles per full period; extra bit keeps 2*cnt from overflowing.
  assign w_tog_target = {r_cnt, 1'b0};
  assign w_owner_req  = bus.req[r_owner];

  // Next-state, ownership and pulse generation decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_done_nxt    = '0;
    w_pulse_nxt   = r_pulse;
    w_div_cnt_nxt = r_div_cnt;
    w_tog_cnt_nxt = r_tog_cnt;
    w_div_nxt     = r_div;
    w_cnt_nxt     = r_cnt;
    w_owner_nxt   = r_owner;
`ifdef PULSE_SCHED_FIXPRIO_EN
`else
    w_rr_nxt      = r_rr;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt   = w_sel;
          w_div_nxt     = w_sel_div;
          w_cnt_nxt     = w_sel_cnt;
          w_grant_nxt   = w_sel_oh;
          w_div_cnt_nxt = '0;
          w_tog_cnt_nxt = '0;
          w_pulse_nxt   = 1'b0;
          if (w_sel_cnt == '0) begin
            // Zero periods requested: grant and complete in one cycle.
            w_state_nxt = S_DONE;
            w_done_nxt  = w_sel_oh;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (!w_owner_req) begin
          // Owner gave up: truncate the waveform, no completion strobe,
          // and pass priority on exactly as a completed run would.
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = '0;
          w_pulse_nxt   = 1'b0;
          w_div_cnt_nxt = '0;
          w_tog_cnt_nxt = '0;
`ifdef PULSE_SCHED_FIXPRIO_EN
`else
          w_rr_nxt      = wrap_idx(r_owner, 1);
`endif
        end else if (r_div_cnt == w_div_last) begin
          w_div_cnt_nxt = '0;
          w_pulse_nxt   = ~r_pulse;
          w_tog_cnt_nxt = w_tog_inc;
          if (w_tog_inc == w_tog_target) begin
            // Even number of toggles, so the waveform ends low here.
            w_state_nxt = S_DONE;
            w_done_nxt  = r_grant;
            w_pulse_nxt = 1'b0;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt   = S_IDLE;
        w_grant_nxt   = '0;
        w_div_cnt_nxt = '0;
        w_tog_cnt_nxt = '0;
`ifdef PULSE_SCHED_FIXPRIO_EN
`else
        w_rr_nxt      = wrap_idx(r_owner, 1);
`endif
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_grant_nxt   = '0;
        w_pulse_nxt   = 1'b0;
        w_div_cnt_nxt = '0;
        w_tog_cnt_nxt = '0;
      end
    endcase
  end

  // State register; reset takes effect immediately, truncating any pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_pulse   <= 1'b0;
      r_div_cnt <= '0;
      r_tog_cnt <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_owner   <= '0;
`ifdef PULSE_SCHED_FIXPRIO_EN
`else
      r_rr      <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_pulse   <= w_pulse_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_tog_cnt <= w_tog_cnt_nxt;
      r_div     <= w_div_nxt;
      r_cnt     <= w_cnt_nxt;
      r_owner   <= w_owner_nxt;
`ifdef PULSE_SCHED_FIXPRIO_EN
`else
      r_rr      <= w_rr_nxt;
`endif
    end
  end

  // All outputs come straight from registers.
  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.pulse_out = r_pulse;
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pulse_scheduler                                            |
// | Purpose  : Self-checking bench for pulse_scheduler: directed scenarios   |
// |            plus random requester traffic against a job-level model.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pulse_scheduler;
  localparam int NREQ  = 4;
  localparam int DIV_W = 4;
  localparam int CNT_W = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic            pulse;
    logic            busy;
    logic [NREQ-1:0] done;
  } exp_t;

  pulse_scheduler_if #(.NREQ(NREQ), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  pulse_scheduler #(.NREQ(NREQ), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Advance one cycle; outputs are then stable and inputs apply to this cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input int i, input int d, input int c);
    bus.div_cfg[i*DIV_W +: DIV_W] = DIV_W'(d);
    bus.cnt_cfg[i*CNT_W +: CNT_W] = CNT_W'(c);
  endtask

  task automatic do_reset();
    bus.req     = '0;
    bus.div_cfg = '0;
    bus.cnt_cfg = '0;
    reset_n     = 1'b0;
    tick();
    tick();
    reset_n     = 1'b1;
  endtask

  task automatic test_reset();
    bus.req     = 4'b1111;
    bus.div_cfg = '0;
    bus.cnt_cfg = {NREQ{4'h1}};
    reset_n     = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    n_checks++; if (bus.pulse_out !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", bus.pulse_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", bus.done); end
    reset_n = 1'b1;
    tick();
    n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", bus.grant); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy: got %b want 1", bus.busy); end
  endtask

  task automatic test_single_run();
    bit exp_p [12] = '{0,0,0,1,1,1,0,0,0,1,1,1};
    do_reset();
    set_cfg(0, 1, 1);
    set_cfg(2, 3, 2);
    bus.req = 4'b0100;
    tick();
    // Late config edits must not affect the run in progress.
    set_cfg(2, 1, 7);
    for (int t = 0; t < 12; t++) begin
      n_checks++;
      if (bus.grant !== 4'b0100 || bus.pulse_out !== exp_p[t] || bus.busy !== 1'b1 || bus.done !== 4'b0000) begin
        n_fail++;
        $display("FAIL single_run t=%0d: got grant=%b pulse=%b busy=%b done=%b want grant=0100 pulse=%b busy=1 done=0000",
                 t, bus.grant, bus.pulse_out, bus.busy, bus.done, exp_p[t]);
      end
      tick();
    end
    n_checks++; if (bus.done !== 4'b0100 || bus.grant !== 4'b0100 || bus.pulse_out !== 1'b0)
      begin n_fail++; $display("FAIL single_done: got done=%b grant=%b pulse=%b want done=0100 grant=0100 pulse=0", bus.done, bus.grant, bus.pulse_out); end
    bus.req = '0;
    tick();
    n_checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 4'b0000)
      begin n_fail++; $display("FAIL single_idle: got grant=%b busy=%b done=%b want 0000 0 0000", bus.grant, bus.busy, bus.done); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_order [4];
    logic [NREQ-1:0] prev;
    int n_grants = 0;
    int gap = 0;
`ifdef PULSE_SCHED_FIXPRIO_EN
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cfg(i, 1, 1);
    bus.req = 4'b1011;
    prev = '0;
    for (int c = 0; c < 60 && n_grants < 4; c++) begin
      tick();
      if (bus.grant !== '0 && prev === '0) begin
        n_checks++;
        if (bus.grant !== exp_order[n_grants]) begin
          n_fail++; $display("FAIL rr_order #%0d: got %b want %b", n_grants, bus.grant, exp_order[n_grants]);
        end
        if (n_grants > 0) begin
          n_checks++;
          if (gap != 1) begin n_fail++; $display("FAIL rr_gap #%0d: got %0d idle cycles want 1", n_grants, gap); end
        end
        n_grants++;
        gap = 0;
      end else if (bus.grant === '0) begin
        gap++;
      end
      prev = bus.grant;
    end
    n_checks++;
    if (n_grants != 4) begin n_fail++; $display("FAIL rr_timeout: got %0d grants want 4", n_grants); end
    bus.req = '0;
  endtask

  task automatic test_edge_cfg();
    do_reset();
    set_cfg(0, 0, 1);
    bus.req = 4'b0001;
    tick();
    n_checks++; if (bus.grant !== 4'b0001 || bus.pulse_out !== 1'b0)
      begin n_fail++; $display("FAIL div0_first: got grant=%b pulse=%b want 0001 0", bus.grant, bus.pulse_out); end
    tick();
    n_checks++; if (bus.pulse_out !== 1'b1 || bus.done !== 4'b0000)
      begin n_fail++; $display("FAIL div0_high: got pulse=%b done=%b want 1 0000", bus.pulse_out, bus.done); end
    tick();
    n_checks++; if (bus.done !== 4'b0001 || bus.pulse_out !== 1'b0)
      begin n_fail++; $display("FAIL div0_done: got done=%b pulse=%b want 0001 0", bus.done, bus.pulse_out); end
    bus.req = '0;
    tick();
    set_cfg(0, 5, 0);
    bus.req = 4'b0001;
    tick();
    n_checks++; if (bus.grant !== 4'b0001 || bus.done !== 4'b0001 || bus.busy !== 1'b1 || bus.pulse_out !== 1'b0)
      begin n_fail++; $display("FAIL cnt0_done: got grant=%b done=%b busy=%b pulse=%b want 0001 0001 1 0", bus.grant, bus.done, bus.busy, bus.pulse_out); end
    bus.req = '0;
    tick();
    n_checks++; if (bus.grant !== 4'b0000 || bus.done !== 4'b0000 || bus.busy !== 1'b0 || bus.pulse_out !== 1'b0)
      begin n_fail++; $display("FAIL cnt0_idle: got grant=%b done=%b busy=%b pulse=%b want 0000 0000 0 0", bus.grant, bus.done, bus.busy, bus.pulse_out); end
  endtask

  task automatic test_abandon();
    bit saw_done = 1'b0;
    do_reset();
    set_cfg(0, 4, 5);
    set_cfg(1, 1, 1);
    bus.req = 4'b0011;
    tick();
    n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL abandon_grant0: got %b want 0001", bus.grant); end
    for (int r = 0; r < 6; r++) begin
      if (bus.done !== 4'b0000) saw_done = 1'b1;
      tick();
    end
    n_checks++; if (bus.pulse_out !== 1'b1) begin n_fail++; $display("FAIL abandon_mid_pulse: got %b want 1", bus.pulse_out); end
    bus.req = 4'b0010;
    tick();
    n_checks++; if (bus.grant !== 4'b0000 || bus.pulse_out !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL abandon_idle: got grant=%b pulse=%b busy=%b want 0000 0 0", bus.grant, bus.pulse_out, bus.busy); end
    if (bus.done !== 4'b0000) saw_done = 1'b1;
    tick();
    n_checks++; if (bus.grant !== 4'b0010) begin n_fail++; $display("FAIL abandon_next_grant: got %b want 0010", bus.grant); end
    if (bus.done !== 4'b0000) saw_done = 1'b1;
    tick();
    n_checks++; if (bus.pulse_out !== 1'b1) begin n_fail++; $display("FAIL abandon_next_pulse: got %b want 1", bus.pulse_out); end
    tick();
    n_checks++; if (bus.done !== 4'b0010) begin n_fail++; $display("FAIL abandon_next_done: got %b want 0010", bus.done); end
    n_checks++; if (saw_done) begin n_fail++; $display("FAIL abandon_no_done: got done strobe want none"); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_cfg(0, 2, 3);
    bus.req = 4'b0001;
    tick();
    tick();
    tick();
    n_checks++; if (bus.pulse_out !== 1'b1) begin n_fail++; $display("FAIL async_pre_pulse: got %b want 1", bus.pulse_out); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL async_grant: got %b want 0000", bus.grant); end
    n_checks++; if (bus.pulse_out !== 1'b0) begin n_fail++; $display("FAIL async_pulse: got %b want 0", bus.pulse_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b want 0", bus.busy); end
    bus.req = '0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Random requesters against a job-level model: each grant expands into
  // a precomputed list of per-cycle outputs built from D, cnt and the owner.
  task automatic test_random();
    exp_t q [$];
    exp_t e;
    exp_t s;
    bit   idle_now;
    int   rr   = 0;
    int   errs = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_now = (q.size() == 0);
      if (idle_now) e = '0;
      else          e = q.pop_front();
      n_checks++;
      if (bus.grant !== e.grant || bus.pulse_out !== e.pulse || bus.busy !== e.busy || bus.done !== e.done) begin
        n_fail++;
        errs++;
        $display("FAIL random cyc=%0d: got grant=%b pulse=%b busy=%b done=%b want grant=%b pulse=%b busy=%b done=%b",
                 cyc, bus.grant, bus.pulse_out, bus.busy, bus.done, e.grant, e.pulse, e.busy, e.done);
        if (errs >= 10) break;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (e.done[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
        end
        set_cfg(i, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      end
      if (idle_now && bus.req != '0) begin
        int w = -1;
        int d;
        int c;
        for (int k = 0; k < NREQ; k++) begin
          int j = (rr + k) % NREQ;
          if (w < 0 && bus.req[j]) w = j;
        end
`ifdef PULSE_SCHED_FIXPRIO_EN
`else
        rr = (w + 1) % NREQ;
`endif
        d = int'(bus.div_cfg[w*DIV_W +: DIV_W]);
        c = int'(bus.cnt_cfg[w*CNT_W +: CNT_W]);
        if (d == 0) d = 1;
        s.grant = NREQ'(1) << w;
        s.busy  = 1'b1;
        s.done  = '0;
        for (int t = 0; t < 2 * d * c; t++) begin
          s.pulse = ((t / d) % 2) == 1;
          q.push_back(s);
        end
        s.pulse = 1'b0;
        s.done  = NREQ'(1) << w;
        q.push_back(s);
      end
      tick();
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req     = '0;
    bus.div_cfg = '0;
    bus.cnt_cfg = '0;
    test_reset();
    test_single_run();
    test_round_robin();
    test_edge_cfg();
    test_abandon();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
